// File: rtl/demux_bank.sv
// demux_bank: routes a stream of words into a bank of NUM_CH channel registers,
// either by explicit select (manual mode) or by an internal round-robin pointer
// (auto mode). Once every channel is loaded the bank is held until out_ack.
// Optional feature: define DEMUX_BANK_SEL_ERR_EN to add the sticky sel_err output.
module demux_bank #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 12,
    parameter int unsigned SEL_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     auto_mode,
    input  logic                     out_ack,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        ch_loaded,
    output logic                     bank_full
`ifdef DEMUX_BANK_SEL_ERR_EN
   ,output logic                     sel_err
`endif
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [PTR_W-1:0]   dest;
    logic               dest_ok;
    logic               sel_ok;
    logic               accept;
    logic [NUM_CH-1:0]  wr_en;
    logic [NUM_CH-1:0]  loaded_nxt;

    assign accept = in_valid & in_ready;
    assign sel_ok = (32'(sel) < NUM_CH);

    // Destination decode: pointer in auto mode, sel in manual mode (dropped if out of range)
    always_comb begin
        dest    = ptr;
        dest_ok = 1'b0;
        wr_en   = '0;
        if (accept) begin
            if (auto_mode) begin
                dest    = ptr;
                dest_ok = 1'b1;
            end else begin
                dest    = PTR_W'(sel);
                dest_ok = sel_ok;
            end
        end
        for (int k = 0; k < int'(NUM_CH); k++) begin
            wr_en[k] = dest_ok && (dest == PTR_W'(k));
        end
    end

    // Next-state logic: fill channels, hold when full, release on out_ack
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        loaded_nxt = ch_loaded;
        case (state)
            FILL: begin
                loaded_nxt = ch_loaded | wr_en;
                if (accept && auto_mode) begin
                    ptr_nxt = (32'(ptr) == NUM_CH - 1) ? '0 : ptr + PTR_W'(1);
                end
                if (&loaded_nxt) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (out_ack) begin
                    loaded_nxt = '0;
                    ptr_nxt    = '0;
                    state_nxt  = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointer, load flags and handshake outputs, registered from next-state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            ch_loaded <= '0;
            in_ready  <= 1'b1;
            bank_full <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            ch_loaded <= loaded_nxt;
            in_ready  <= (state_nxt == FILL);
            bank_full <= (state_nxt == FULL);
        end
    end

    // Channel data registers; only the addressed channel is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (wr_en[k]) begin
                    out_data[k*DATA_W +: DATA_W] <= in_data;
                end
            end
        end
    end

`ifdef DEMUX_BANK_SEL_ERR_EN
    // Sticky flag for accepted manual words with an out-of-range select; cleared on release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (state == FULL && out_ack) begin
            sel_err <= 1'b0;
        end else if (accept && !auto_mode && !sel_ok) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_bank.sv
// Self-checking bench for demux_bank: a table of directed vectors, hand-written
// multi-cycle sequences, and randomized traffic checked against a behavioural model.
module tb_demux_bank;

    localparam int NA = 12;
    localparam int WA = 8;
    localparam int SA = 4;
    localparam int NB = 4;
    localparam int WB = 16;
    localparam int SB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic              a_valid, a_ready, a_auto, a_ack, a_full;
    logic [WA-1:0]     a_data;
    logic [SA-1:0]     a_sel;
    logic [NA*WA-1:0]  a_out;
    logic [NA-1:0]     a_loaded;
    logic              b_valid, b_ready, b_auto, b_ack, b_full;
    logic [WB-1:0]     b_data;
    logic [SB-1:0]     b_sel;
    logic [NB*WB-1:0]  b_out;
    logic [NB-1:0]     b_loaded;
`ifdef DEMUX_BANK_SEL_ERR_EN
    logic              a_err, b_err;
`endif

    demux_bank #(.DATA_W(WA), .NUM_CH(NA), .SEL_W(SA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .sel(a_sel), .auto_mode(a_auto), .out_ack(a_ack),
        .out_data(a_out), .ch_loaded(a_loaded), .bank_full(a_full)
`ifdef DEMUX_BANK_SEL_ERR_EN
       ,.sel_err(a_err)
`endif
    );

    demux_bank #(.DATA_W(WB), .NUM_CH(NB), .SEL_W(SB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .sel(b_sel), .auto_mode(b_auto), .out_ack(b_ack),
        .out_data(b_out), .ch_loaded(b_loaded), .bank_full(b_full)
`ifdef DEMUX_BANK_SEL_ERR_EN
       ,.sel_err(b_err)
`endif
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model of instance A
    int m_data[NA];
    bit m_loaded[NA];
    int m_ptr;
    bit m_full;
    bit m_err;

    typedef struct {
        logic        valid;
        logic        auto_m;
        logic        ack;
        logic [3:0]  sel;
        logic [7:0]  data;
        logic [11:0] exp_loaded;
        logic        exp_full;
        logic        exp_ready;
        int          chk_ch;
        logic [7:0]  exp_val;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NA; k++) begin
            m_data[k]   = 0;
            m_loaded[k] = 1'b0;
        end
        m_ptr  = 0;
        m_full = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic [3:0] s,
                              input logic au, input logic ak);
        int  dest;
        bit  all;
        dest = -1;
        if (!m_full) begin
            if (v) begin
                if (au) begin
                    dest  = m_ptr;
                    m_ptr = (m_ptr + 1) % NA;
                end else if (int'(s) < NA) begin
                    dest = int'(s);
                end else begin
                    m_err = 1'b1;
                end
                if (dest >= 0) begin
                    m_data[dest]   = int'(d);
                    m_loaded[dest] = 1'b1;
                end
            end
            all = 1'b1;
            for (int k = 0; k < NA; k++) all = all & m_loaded[k];
            m_full = all;
        end else if (ak) begin
            for (int k = 0; k < NA; k++) m_loaded[k] = 1'b0;
            m_ptr  = 0;
            m_full = 1'b0;
            m_err  = 1'b0;
        end
    endtask

    function automatic logic [NA*WA-1:0] model_vec();
        logic [NA*WA-1:0] v;
        for (int k = 0; k < NA; k++) v[k*WA +: WA] = WA'(m_data[k]);
        return v;
    endfunction

    function automatic logic [NA-1:0] model_loaded();
        logic [NA-1:0] v;
        for (int k = 0; k < NA; k++) v[k] = m_loaded[k];
        return v;
    endfunction

    task automatic check_a(input string tag);
        chk({tag, ".data"},   128'(a_out),    128'(model_vec()));
        chk({tag, ".loaded"}, 128'(a_loaded), 128'(model_loaded()));
        chk({tag, ".full"},   128'(a_full),   128'(m_full));
        chk({tag, ".ready"},  128'(a_ready),  128'(!m_full));
`ifdef DEMUX_BANK_SEL_ERR_EN
        chk({tag, ".sel_err"}, 128'(a_err), 128'(m_err));
`endif
    endtask

    // One clock on instance A with the model advanced alongside; sampled 1 ns after the edge
    task automatic step_a(input logic v, input logic [7:0] d, input logic [3:0] s,
                          input logic au, input logic ak, input string tag);
        a_valid = v; a_data = d; a_sel = s; a_auto = au; a_ack = ak;
        @(posedge clk);
        model_step(v, d, s, au, ak);
        #1;
        a_valid = 1'b0; a_ack = 1'b0;
        check_a(tag);
    endtask

    task automatic step_b(input logic v, input logic [15:0] d, input logic [1:0] s, input logic ak);
        b_valid = v; b_data = d; b_sel = s; b_auto = 1'b0; b_ack = ak;
        @(posedge clk);
        #1;
        b_valid = 1'b0; b_ack = 1'b0;
    endtask

    task automatic do_reset();
        a_valid = 1'b0; a_ack = 1'b0; a_auto = 1'b0; a_sel = '0; a_data = '0;
        b_valid = 1'b0; b_ack = 1'b0; b_auto = 1'b0; b_sel = '0; b_data = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [NA*WA-1:0] exp_bank;

        // Directed vector table for instance A
        for (int i = 0; i < 12; i++) begin
            tbl[i] = '{1'b1, 1'b0, 1'b0, 4'(i), 8'(8'h10 + i), 12'((1 << (i + 1)) - 1),
                       (i == 11), (i != 11), i, 8'(8'h10 + i)};
        end
        tbl[12] = '{1'b1, 1'b0, 1'b0, 4'd0,  8'h55, 12'hFFF, 1'b1, 1'b0, 0, 8'h10};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 4'd0,  8'h00, 12'h000, 1'b0, 1'b1, 0, 8'h10};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 4'd0,  8'h00, 12'h000, 1'b0, 1'b1, 0, 8'h10};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 4'd13, 8'hFF, 12'h000, 1'b0, 1'b1, 0, 8'h10};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 4'd7,  8'hA0, 12'h001, 1'b0, 1'b1, 0, 8'hA0};

        do_reset();
        chk("rst.data",   128'(a_out),    128'(0));
        chk("rst.loaded", 128'(a_loaded), 128'(0));
        chk("rst.full",   128'(a_full),   128'(0));
        chk("rst.ready",  128'(a_ready),  128'(1));
`ifdef DEMUX_BANK_SEL_ERR_EN
        chk("rst.sel_err", 128'(a_err), 128'(0));
`endif

        for (int i = 0; i < 17; i++) begin
            step_a(tbl[i].valid, tbl[i].data, tbl[i].sel, tbl[i].auto_m, tbl[i].ack,
                   $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.t_loaded", i), 128'(a_loaded), 128'(tbl[i].exp_loaded));
            chk($sformatf("tbl%0d.t_full", i),   128'(a_full),   128'(tbl[i].exp_full));
            chk($sformatf("tbl%0d.t_ready", i),  128'(a_ready),  128'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d.t_ch", i),     128'(a_out[tbl[i].chk_ch*WA +: WA]),
                128'(tbl[i].exp_val));
`ifdef DEMUX_BANK_SEL_ERR_EN
            if (i == 15) chk("tbl15.t_sel_err", 128'(a_err), 128'(1));
`endif
        end

        // Auto fill A0..AB, release, pointer restarts at channel 0
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step_a(1'b1, 8'(8'hA0 + i), 4'($urandom_range(0, 15)), 1'b1, 1'b0, "auto");
            exp_bank[i*WA +: WA] = 8'(8'hA0 + i);
        end
        chk("auto.bank", 128'(a_out), 128'(exp_bank));
        chk("auto.full", 128'(a_full), 128'(1));
        step_a(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, "auto_ack");
        chk("auto_ack.bank",   128'(a_out),    128'(exp_bank));
        chk("auto_ack.loaded", 128'(a_loaded), 128'(0));
        step_a(1'b1, 8'h77, 4'd5, 1'b1, 1'b0, "auto_next");
        chk("auto_next.ch0",    128'(a_out[0 +: WA]), 128'(8'h77));
        chk("auto_next.loaded", 128'(a_loaded),       128'(1));

        // Asynchronous reset mid-clock after five auto writes
        do_reset();
        for (int i = 0; i < 5; i++) step_a(1'b1, 8'(8'h31 + i), 4'd0, 1'b1, 1'b0, "pre_rst");
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst.data",   128'(a_out),    128'(0));
        chk("async_rst.loaded", 128'(a_loaded), 128'(0));
        chk("async_rst.full",   128'(a_full),   128'(0));
        chk("async_rst.ready",  128'(a_ready),  128'(1));
        @(posedge clk);
        #2 rst_n = 1'b1;
        step_a(1'b1, 8'h99, 4'd3, 1'b1, 1'b0, "post_rst");
        chk("post_rst.ch0",    128'(a_out[0 +: WA]), 128'(8'h99));
        chk("post_rst.loaded", 128'(a_loaded),       128'(1));

        // Four-channel, 16-bit instance: rewrite channel 2, then complete the bank
        do_reset();
        step_b(1'b1, 16'h1234, 2'd2, 1'b0);
        chk("b.ch2_first", 128'(b_out[2*WB +: WB]), 128'(16'h1234));
        step_b(1'b1, 16'hBEEF, 2'd2, 1'b0);
        chk("b.ch2_rewrite", 128'(b_out[2*WB +: WB]), 128'(16'hBEEF));
        chk("b.loaded_2",    128'(b_loaded),          128'(4'b0100));
        chk("b.full_2",      128'(b_full),            128'(0));
        step_b(1'b1, 16'h0A0A, 2'd0, 1'b0);
        chk("b.full_0", 128'(b_full), 128'(0));
        step_b(1'b1, 16'h1B1B, 2'd1, 1'b0);
        chk("b.loaded_01", 128'(b_loaded), 128'(4'b0111));
        chk("b.full_1",    128'(b_full),   128'(0));
        step_b(1'b1, 16'h3C3C, 2'd3, 1'b0);
        chk("b.full_3",  128'(b_full),  128'(1));
        chk("b.ready_3", 128'(b_ready), 128'(0));
        chk("b.bank",    128'(b_out),   128'({16'h3C3C, 16'hBEEF, 16'h1B1B, 16'h0A0A}));

        // Randomized traffic on instance A against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step_a($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom_range(0, 15)),
                   $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                   $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
